// File: rtl/complex_gates_sweeper_if.sv
// Gate-side and control bundle between the sweeper and its environment.
// The master drives start/abort and the gate response; the slave (sweeper) drives operands and results.
interface complex_gates_sweeper_if #(
  parameter int CNT_W = 17
);
  logic             start;
  logic             abort;
  logic             dut_out;
  logic [7:0]       x_o;
  logic [7:0]       y_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [15:0]      first_hit;
  logic             hit_valid;

  modport master (
    output start, abort, dut_out,
    input  x_o, y_o, busy, done, ones_cnt, err_cnt, first_hit, hit_valid
  );

  modport slave (
    input  start, abort, dut_out,
    output x_o, y_o, busy, done, ones_cnt, err_cnt, first_hit, hit_valid
  );
endinterface

// File: rtl/complex_gates_sweeper.sv
// Exhaustive {y,x} sweeper and checker for the 8-bit AND-OR-AND-OR gate; each vector is held SETTLE+1 cycles.
// No backpressure: start is ignored while busy, abort returns to idle at the next edge without sampling.
module complex_gates_sweeper #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  complex_gates_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0]       LP_SETTLE  = 4'(SETTLE);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [15:0]      r_idx;
  logic [3:0]       r_settle;
  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_err;
  logic [15:0]      r_first;
  logic             r_hv;

  logic [7:0]       w_t;
  logic             w_exp;
  logic             w_sample;
  logic [15:0]      w_idx_nxt;
  logic [CNT_W-1:0] w_ones_nxt;
  logic [CNT_W-1:0] w_err_nxt;

  // Golden response is taken from the registered operands the gate is actually seeing.
  assign w_t   = r_x & r_y;
  assign w_exp = ((w_t[0] | w_t[1]) & (w_t[2] | w_t[3])) |
                 ((w_t[4] | w_t[5]) & (w_t[6] | w_t[7]));

  assign w_sample  = (r_settle == LP_SETTLE);
  assign w_idx_nxt = r_idx + 16'd1;

  assign w_ones_nxt = (bus.dut_out && (r_ones != LP_CNT_MAX)) ? r_ones + CNT_W'(1) : r_ones;
  assign w_err_nxt  = ((bus.dut_out != w_exp) && (r_err != LP_CNT_MAX)) ? r_err + CNT_W'(1) : r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= 16'd0;
      r_settle <= 4'd0;
      r_x      <= 8'd0;
      r_y      <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ones   <= '0;
      r_err    <= '0;
      r_first  <= 16'd0;
      r_hv     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_x    <= 8'd0;
          r_y    <= 8'd0;
          if (bus.start) begin
            r_state  <= HOLD;
            r_idx    <= 16'd0;
            r_settle <= 4'd0;
            r_busy   <= 1'b1;
            r_ones   <= '0;
            r_err    <= '0;
            r_first  <= 16'd0;
            r_hv     <= 1'b0;
          end
        end

        HOLD: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_x     <= 8'd0;
            r_y     <= 8'd0;
          end else if (w_sample) begin
            r_ones <= w_ones_nxt;
            r_err  <= w_err_nxt;
            if (bus.dut_out && !r_hv) begin
              r_first <= r_idx;
              r_hv    <= 1'b1;
            end
            if (r_idx == 16'hFFFF) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_x     <= 8'd0;
              r_y     <= 8'd0;
            end else begin
              r_idx    <= w_idx_nxt;
              r_x      <= w_idx_nxt[7:0];
              r_y      <= w_idx_nxt[15:8];
              r_settle <= 4'd0;
            end
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end

        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_o       = r_x;
  assign bus.y_o       = r_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ones_cnt  = r_ones;
  assign bus.err_cnt   = r_err;
  assign bus.first_hit = r_first;
  assign bus.hit_valid = r_hv;

endmodule
